// File: rtl/eth_tx_sched.sv
// 10BASE-T transmit-line scheduler: arbitrates the TX pair between link pulses,
// frame data, the end-of-frame positive hold (ETD) and the inter-packet gap.
module eth_tx_sched #(
  parameter int unsigned NLP_PERIOD = 640000,
  parameter int unsigned NLP_WIDTH  = 4,
  parameter int unsigned ETD_CYCLES = 10,
  parameter int unsigned IPG_CYCLES = 384,
  parameter int unsigned JAB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  output logic       frame_ack,
  output logic       tx_start,
  input  logic       tx_data,
  input  logic       tx_done,
  output logic       line_out,
  output logic       line_oe,
  output logic       busy,
  output logic       nlp_active,
  output logic       jabber,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NLP   = 3'd1,
    S_START = 3'd2,
    S_FRAME = 3'd3,
    S_ETD   = 3'd4,
    S_IPG   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] NLP_LAST = CNT_W'(NLP_PERIOD - 1);
  localparam logic [CNT_W-1:0] NLPW_LAST = CNT_W'(NLP_WIDTH - 1);
  localparam logic [CNT_W-1:0] ETD_LAST = CNT_W'(ETD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);
  localparam logic [CNT_W-1:0] JAB_LAST = CNT_W'(JAB_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nlp_cnt_q, nlp_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             nlp_due;
  logic             state_entry;

  logic frame_ack_q, frame_ack_d;
  logic tx_start_q, tx_start_d;
  logic line_out_q, line_out_d;
  logic line_oe_q, line_oe_d;
  logic busy_q, busy_d;
  logic nlp_active_q, nlp_active_d;
  logic jabber_q, jabber_d;

  assign nlp_due     = (nlp_cnt_q == NLP_LAST);
  assign state_entry = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A pending link pulse takes priority over a waiting frame.
        if (nlp_due)        state_d = S_NLP;
        else if (frame_req) state_d = S_START;
      end
      S_NLP:   if (seq_cnt_q == NLPW_LAST) state_d = S_IDLE;
      S_START: state_d = S_FRAME;
      S_FRAME: if (tx_done || seq_cnt_q == JAB_LAST) state_d = S_ETD;
      S_ETD:   if (seq_cnt_q == ETD_LAST) state_d = S_IPG;
      S_IPG:   if (seq_cnt_q == IPG_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seq_cnt_d = seq_cnt_q + 1'b1;
    if (state_entry || state_q == S_IDLE) seq_cnt_d = '0;
  end

  // The link-pulse timer stays cleared for the whole pulse, so the next period
  // is measured from the first IDLE cycle after it; ETD entry also restarts it.
  always_comb begin
    nlp_cnt_d = nlp_cnt_q;
    if (state_q == S_NLP || state_d == S_NLP ||
        (state_d == S_ETD && state_q != S_ETD)) begin
      nlp_cnt_d = '0;
    end else if (!nlp_due) begin
      nlp_cnt_d = nlp_cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the cycle in which state_q holds that state.
  always_comb begin
    frame_ack_d  = 1'b0;
    tx_start_d   = 1'b0;
    line_out_d   = 1'b0;
    line_oe_d    = 1'b0;
    nlp_active_d = 1'b0;
    busy_d       = (state_d != S_IDLE);
    jabber_d     = (state_q == S_FRAME) && (state_d == S_ETD) && !tx_done;
    case (state_d)
      S_NLP: begin
        line_oe_d    = 1'b1;
        line_out_d   = 1'b1;
        nlp_active_d = 1'b1;
      end
      S_START: begin
        frame_ack_d = 1'b1;
        tx_start_d  = 1'b1;
      end
      S_FRAME: begin
        line_oe_d  = 1'b1;
        line_out_d = tx_data;
      end
      S_ETD: begin
        line_oe_d  = 1'b1;
        line_out_d = 1'b1;
      end
      default: begin
        line_oe_d  = 1'b0;
        line_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      nlp_cnt_q    <= '0;
      seq_cnt_q    <= '0;
      frame_ack_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      line_out_q   <= 1'b0;
      line_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      nlp_active_q <= 1'b0;
      jabber_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      nlp_cnt_q    <= nlp_cnt_d;
      seq_cnt_q    <= seq_cnt_d;
      frame_ack_q  <= frame_ack_d;
      tx_start_q   <= tx_start_d;
      line_out_q   <= line_out_d;
      line_oe_q    <= line_oe_d;
      busy_q       <= busy_d;
      nlp_active_q <= nlp_active_d;
      jabber_q     <= jabber_d;
    end
  end

  assign frame_ack   = frame_ack_q;
  assign tx_start    = tx_start_q;
  assign line_out    = line_out_q;
  assign line_oe     = line_oe_q;
  assign busy        = busy_q;
  assign nlp_active  = nlp_active_q;
  assign jabber      = jabber_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched with shortened timing parameters; expected output
// vectors are keyed by cycle number counted from reset release.
module tb_eth_tx_sched;

  localparam int P = 300;
  localparam int W = 4;
  localparam int E = 10;
  localparam int G = 40;
  localparam int J = 200;

  // {busy, line_oe, line_out, nlp_active, frame_ack, tx_start, jabber}
  localparam logic [6:0] V_IDLE  = 7'b000_0000;
  localparam logic [6:0] V_NLP   = 7'b111_1000;
  localparam logic [6:0] V_START = 7'b100_0110;
  localparam logic [6:0] V_F1    = 7'b111_0000;
  localparam logic [6:0] V_F0    = 7'b110_0000;
  localparam logic [6:0] V_ETD   = 7'b111_0000;
  localparam logic [6:0] V_ETDJ  = 7'b111_0001;
  localparam logic [6:0] V_IPG   = 7'b100_0000;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       frame_req;
  logic       frame_ack;
  logic       tx_start;
  logic       tx_data;
  logic       tx_done;
  logic       line_out;
  logic       line_oe;
  logic       busy;
  logic       nlp_active;
  logic       jabber;
  logic [2:0] dbg_state;
  logic [6:0] obs;

  int   cyc;
  int   checks;
  int   failures;
  int   ack_cnt;
  int   jab_cnt;
  vec_t tbl[$];
  vec_t sb_q[$];

  eth_tx_sched #(
    .NLP_PERIOD(P), .NLP_WIDTH(W), .ETD_CYCLES(E),
    .IPG_CYCLES(G), .JAB_CYCLES(J), .CNT_W(21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .frame_ack(frame_ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .line_out(line_out), .line_oe(line_oe), .busy(busy),
    .nlp_active(nlp_active), .jabber(jabber), .dbg_state_o(dbg_state)
  );

  assign obs = {busy, line_oe, line_out, nlp_active, frame_ack, tx_start, jabber};

  // clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog cyc=%0d expected the test to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_now(input string n, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", n, cyc, got, exp);
    end
  endtask

  task automatic t(input string n, input int c, input logic [6:0] v);
    vec_t r;
    r.name = n; r.cyc = c; r.exp = v;
    tbl.push_back(r);
  endtask

  task automatic expect_at(input int c, input logic [6:0] v, input string n);
    vec_t r;
    r.name = n; r.cyc = c; r.exp = v;
    sb_q.push_back(r);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_ack) ack_cnt++;
        if (jabber)    jab_cnt++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
          if (sb_q[i].cyc == cyc) begin
            check_now(sb_q[i].name, obs, sb_q[i].exp);
            sb_q.delete(i);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request_at(input int c, output int s);
    int n;
    wait_cyc(c);
    frame_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_ack && n < 2000);
    frame_req = 1'b0;
    s = cyc;
    checks++;
    if (!frame_ack) begin
      failures++;
      $display("FAIL ack_timeout cyc=%0d got=0 exp=1", cyc);
    end
  endtask

  task automatic send_frame(input int s, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      wait_cyc(s + 1 + k);
      tx_data = 1'($urandom_range(0, 1));
      if (k < nbits - 1) expect_at(s + 2 + k, tx_data ? V_F1 : V_F0, "frame_bit");
      else               tx_done = 1'b1;
    end
    wait_cyc(s + nbits + 1);
    tx_done = 1'b0;
    tx_data = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < tbl.size(); i++) expect_at(tbl[i].cyc, tbl[i].exp, tbl[i].name);
    tbl.delete();
  endtask

  task automatic flush_pending(input string n);
    while (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_%s cyc=%0d got=unchecked exp=%b", n, sb_q[0].name, sb_q[0].cyc, sb_q[0].exp);
      sb_q.delete(0);
    end
  endtask

  initial begin
    int s;
    checks = 0; failures = 0; ack_cnt = 0; jab_cnt = 0;
    frame_req = 1'b0; tx_data = 1'b0; tx_done = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    fork monitor_loop(); join_none

    // phase 1 fixed points: idle NLPs, frame, NLP priority, IPG hold-off, jabber
    t("rst_idle", 0, V_IDLE);      t("pre_nlp1", P - 1, V_IDLE);
    t("nlp1_first", P, V_NLP);     t("nlp1_last", P + W - 1, V_NLP);
    t("nlp1_end", P + W, V_IDLE);  t("pre_nlp2", 2*P + 3, V_IDLE);
    t("nlp2_first", 2*P + 4, V_NLP); t("nlp2_last", 2*P + 7, V_NLP);
    t("nlp2_end", 2*P + 8, V_IDLE);
    t("req_idle", 618, V_IDLE);    t("ack", 619, V_START);
    t("frame_first", 620, V_F0);   t("etd_first", 680, V_ETD);
    t("etd_last", 689, V_ETD);     t("ipg_first", 690, V_IPG);
    t("ipg_last", 729, V_IPG);     t("idle_after_ipg", 730, V_IDLE);
    t("pre_nlp3", 979, V_IDLE);    t("nlp_prio_first", 980, V_NLP);
    t("nlp_prio_last", 983, V_NLP); t("idle_after_nlp", 984, V_IDLE);
    t("ack_after_nlp", 985, V_START); t("frame2_first", 986, V_F0);
    t("etd2_first", 1006, V_ETD);  t("done_in_etd", 1009, V_ETD);
    t("etd2_last", 1015, V_ETD);   t("ipg2_first", 1016, V_IPG);
    t("req_in_ipg", 1020, V_IPG);  t("ipg2_last", 1055, V_IPG);
    t("idle_held_req", 1056, V_IDLE); t("ack_after_ipg", 1057, V_START);
    t("jab_frame_first", 1058, V_F0); t("jab_frame_last", 1257, V_F0);
    t("jabber_pulse", 1258, V_ETDJ); t("jabber_once", 1259, V_ETD);
    t("jab_etd_last", 1267, V_ETD); t("jab_ipg_first", 1268, V_IPG);
    t("no_old_nlp", 1305, V_IPG);  t("jab_ipg_last", 1307, V_IPG);
    t("jab_idle", 1308, V_IDLE);   t("done_in_idle", 1401, V_IDLE);
    t("pre_nlp_jab", 1557, V_IDLE); t("nlp_after_etd", 1558, V_NLP);
    t("nlp_after_etd_last", 1561, V_NLP); t("idle_after_nlp4", 1562, V_IDLE);
    t("req4_idle", 1570, V_IDLE);  t("ack4", 1571, V_START);
    t("frame_mid", 1590, V_F1);

    repeat (3) @(posedge clk);
    #1 check_now("reset_outputs", obs, V_IDLE);
    @(posedge clk);
    #2 rst_n = 1'b1;
    load_table();

    request_at(618, s);
    send_frame(s, 60);
    request_at(P + 679, s);
    send_frame(s, 20);
    wait_cyc(1008); tx_done = 1'b1;
    wait_cyc(1009); tx_done = 1'b0;
    request_at(1020, s);
    wait_cyc(1400); tx_done = 1'b1;
    wait_cyc(1401); tx_done = 1'b0;
    request_at(1570, s);
    wait_cyc(1572); tx_data = 1'b1;
    wait_cyc(1591);
    flush_pending("phase1");

    // asynchronous reset in the middle of a frame
    #2 rst_n = 1'b0;
    tx_data = 1'b0;
    #1 check_now("async_rst_outputs", obs, V_IDLE);
    check_now("async_rst_state", {4'b0, dbg_state}, 7'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    t("rst2_idle", 0, V_IDLE);     t("rst2_no_ack_a", 1, V_IDLE);
    t("rst2_no_ack_b", 20, V_IDLE); t("rst2_pre_nlp", P - 1, V_IDLE);
    t("rst2_nlp_first", P, V_NLP); t("rst2_nlp_last", P + W - 1, V_NLP);
    t("rst2_nlp_end", P + W, V_IDLE);
    load_table();
    wait_cyc(P + W + 2);
    flush_pending("phase2");

    checks++;
    if (ack_cnt != 4) begin
      failures++;
      $display("FAIL ack_count got=%0d exp=4", ack_cnt);
    end
    checks++;
    if (jab_cnt != 1) begin
      failures++;
      $display("FAIL jabber_count got=%0d exp=1", jab_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
